// File: rtl/occ_chk_pkg.sv
// Shared constants for the occupancy checker: state encoding, log file name and result tags.
package occ_chk_pkg;

   localparam logic [1:0] ST_WARMUP = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_HALT   = 2'd2;

   typedef enum logic [1:0] {
      StWarmup = ST_WARMUP,
      StCheck  = ST_CHECK,
      StHalt   = ST_HALT
   } occ_state_e;

   localparam LOG_FILE   = "occ_chk_log.txt";
   localparam LOG_HEADER = "time inc dec expected car_count result";
   localparam TAG_PASS   = "PASS";
   localparam TAG_FAIL   = "FAIL";

endpackage

// File: rtl/occ_chk_delay.sv
// Delay line for the reference count: tap LAT-1 of a pipe whose stage 0 is the input itself.
module occ_chk_delay
   import occ_chk_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (LAT <= 1) begin : g_direct
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, en};
      assign dout = din;
   end else begin : g_pipe
      logic [WIDTH-1:0] pipe_q [LAT-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < int'(LAT) - 1; i++) pipe_q[i] <= '0;
         end else if (en) begin
            pipe_q[0] <= din;
            for (int i = 1; i < int'(LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign dout = pipe_q[LAT-2];
   end

endmodule

// File: rtl/occupancy_checker.sv
// Self-checking monitor for up/down occupancy counters; compares a saturating reference count
// against the DUT count after LAT cycles. Define OCC_CHK_LOG_EN for a simulation-only text log.
module occupancy_checker
   import occ_chk_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned MAX_COUNT    = 2**WIDTH - 1,
   parameter int unsigned LAT          = 1,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned STOP_ON_FAIL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_exp,
   input  logic             dec_exp,
   input  logic [WIDTH-1:0] car_count,
   output logic [WIDTH-1:0] exp_count,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic             chk_fail,
   output logic             err_sticky,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] check_cnt,
   output logic [31:0]      first_fail_cycle,
   output logic [1:0]       state
);

   localparam logic [WIDTH:0]   MaxExt   = (WIDTH+1)'(MAX_COUNT);
   localparam logic [WIDTH-1:0] MaxCnt   = WIDTH'(MAX_COUNT);
   localparam logic [2:0]       WarmLast = 3'(LAT - 1);

   occ_state_e       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [2:0]       warm_q, warm_d;
   logic [31:0]      cycle_q, cycle_d;
   logic             valid_q, valid_d, pass_q, pass_d, fail_q, fail_d, err_q, err_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d, ccnt_q, ccnt_d;
   logic [31:0]      first_q, first_d;
   logic [WIDTH-1:0] target;
   logic [WIDTH:0]   count_up;

   occ_chk_delay #(
      .WIDTH (WIDTH),
      .LAT   (LAT)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != StHalt),
      .din  (count_q),
      .dout (target)
   );

   // Widened by one bit so the ceiling compare sees the carry instead of a wrapped value.
   assign count_up = {1'b0, count_q} + (WIDTH+1)'(1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      warm_d  = warm_q;
      cycle_d = cycle_q;
      valid_d = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      err_d   = err_q;
      fcnt_d  = fcnt_q;
      ccnt_d  = ccnt_q;
      first_d = first_q;

      if (state_q != StHalt) begin
         cycle_d = cycle_q + 32'd1;
         if (inc_exp && !dec_exp) begin
            count_d = (count_up > MaxExt) ? MaxCnt : count_up[WIDTH-1:0];
         end else if (dec_exp && !inc_exp) begin
            count_d = (count_q == '0) ? '0 : count_q - WIDTH'(1);
         end
      end

      case (state_q)
         StWarmup: begin
            if (warm_q == WarmLast) state_d = StCheck;
            else                    warm_d  = warm_q + 3'd1;
         end
         StCheck: begin
            valid_d = 1'b1;
            if (ccnt_q != '1) ccnt_d = ccnt_q + CNT_W'(1);
            if (car_count == target) begin
               pass_d = 1'b1;
            end else begin
               fail_d = 1'b1;
               err_d  = 1'b1;
               if (!err_q) first_d = cycle_q;
               if (fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
               if (STOP_ON_FAIL != 0) state_d = StHalt;
            end
         end
         StHalt:  ;
         default: state_d = StWarmup;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StWarmup;
         count_q <= '0;
         warm_q  <= '0;
         cycle_q <= '0;
         valid_q <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         err_q   <= 1'b0;
         fcnt_q  <= '0;
         ccnt_q  <= '0;
         first_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         warm_q  <= warm_d;
         cycle_q <= cycle_d;
         valid_q <= valid_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         fcnt_q  <= fcnt_d;
         ccnt_q  <= ccnt_d;
         first_q <= first_d;
      end
   end

   assign exp_count        = count_q;
   assign chk_valid        = valid_q;
   assign chk_pass         = pass_q;
   assign chk_fail         = fail_q;
   assign err_sticky       = err_q;
   assign fail_cnt         = fcnt_q;
   assign check_cnt        = ccnt_q;
   assign first_fail_cycle = first_q;
   assign state            = state_q;

`ifdef OCC_CHK_LOG_EN
   initial begin
      $display("%s", LOG_HEADER);
   end

   always @(posedge clk) begin
      if (rst) begin
         $display("%0t RESET", $time);
      end else if (state_q == StCheck) begin
         $display("%0t %0d %0d %0d %0d %s", $time, inc_exp, dec_exp, target, car_count,
                  (car_count == target) ? TAG_PASS : TAG_FAIL);
      end
   end
`else
`endif

endmodule

// File: tb/tb_occupancy_checker.sv
// Bench for occupancy_checker: four instances (LAT=1, LAT=3, LAT=1 on a 3-stage DUT, stop-on-fail)
// driven together and compared each cycle against a history-based reference model.
module tb_occupancy_checker;

   localparam int NI = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, inc, dec;
   logic [3:0] car     [NI];
   logic [3:0] o_exp   [NI];
   logic       o_val   [NI];
   logic       o_pass  [NI];
   logic       o_fail  [NI];
   logic       o_err   [NI];
   logic [15:0] o_fcnt [NI];
   logic [15:0] o_ccnt [NI];
   logic [31:0] o_first[NI];
   logic [1:0]  o_state[NI];
   logic [3:0]  f2, c2;

   assign o_fcnt[2] = {12'd0, f2};
   assign o_ccnt[2] = {12'd0, c2};

   occupancy_checker #(.WIDTH(4), .MAX_COUNT(15), .LAT(1), .CNT_W(16), .STOP_ON_FAIL(0)) u_lat1 (
      .clk(clk), .rst(rst), .inc_exp(inc), .dec_exp(dec), .car_count(car[0]),
      .exp_count(o_exp[0]), .chk_valid(o_val[0]), .chk_pass(o_pass[0]), .chk_fail(o_fail[0]),
      .err_sticky(o_err[0]), .fail_cnt(o_fcnt[0]), .check_cnt(o_ccnt[0]),
      .first_fail_cycle(o_first[0]), .state(o_state[0]));

   occupancy_checker #(.WIDTH(4), .MAX_COUNT(15), .LAT(3), .CNT_W(16), .STOP_ON_FAIL(0)) u_lat3 (
      .clk(clk), .rst(rst), .inc_exp(inc), .dec_exp(dec), .car_count(car[1]),
      .exp_count(o_exp[1]), .chk_valid(o_val[1]), .chk_pass(o_pass[1]), .chk_fail(o_fail[1]),
      .err_sticky(o_err[1]), .fail_cnt(o_fcnt[1]), .check_cnt(o_ccnt[1]),
      .first_fail_cycle(o_first[1]), .state(o_state[1]));

   occupancy_checker #(.WIDTH(4), .MAX_COUNT(15), .LAT(1), .CNT_W(4), .STOP_ON_FAIL(0)) u_mis (
      .clk(clk), .rst(rst), .inc_exp(inc), .dec_exp(dec), .car_count(car[2]),
      .exp_count(o_exp[2]), .chk_valid(o_val[2]), .chk_pass(o_pass[2]), .chk_fail(o_fail[2]),
      .err_sticky(o_err[2]), .fail_cnt(f2), .check_cnt(c2),
      .first_fail_cycle(o_first[2]), .state(o_state[2]));

   occupancy_checker #(.WIDTH(4), .MAX_COUNT(15), .LAT(1), .CNT_W(16), .STOP_ON_FAIL(1)) u_stop (
      .clk(clk), .rst(rst), .inc_exp(inc), .dec_exp(dec), .car_count(car[3]),
      .exp_count(o_exp[3]), .chk_valid(o_val[3]), .chk_pass(o_pass[3]), .chk_fail(o_fail[3]),
      .err_sticky(o_err[3]), .fail_cnt(o_fcnt[3]), .check_cnt(o_ccnt[3]),
      .first_fail_cycle(o_first[3]), .state(o_state[3]));

   // Per-instance configuration and reference state.
   int lat_of  [NI] = '{1, 3, 1, 1};
   int stop_of [NI] = '{0, 0, 0, 1};
   int cmax    [NI] = '{65535, 65535, 15, 65535};
   bit three_stage [NI] = '{0, 1, 1, 0};

   int hist[$];  // hist[k] = reference count after the k-th edge since reset
   int k;
   int m_exp[NI], m_val[NI], m_pass[NI], m_fail[NI], m_err[NI];
   int m_fcnt[NI], m_ccnt[NI], m_first[NI], m_state[NI], m_halt[NI];
   int fault[NI];
   int n_assert = 0;
   int n_fail   = 0;

   function automatic int next_count(int c, bit i, bit d);
      if (i && !d) return (c < 15) ? c + 1 : 15;
      if (d && !i) return (c > 0) ? c - 1 : 0;
      return c;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic clear_model();
      hist = {0};
      k = 0;
      for (int x = 0; x < NI; x++) begin
         m_exp[x] = 0; m_val[x] = 0; m_pass[x] = 0; m_fail[x] = 0; m_err[x] = 0;
         m_fcnt[x] = 0; m_ccnt[x] = 0; m_first[x] = 0; m_state[x] = 0; m_halt[x] = 0;
      end
   endtask

   task automatic step(bit r, bit i, bit d);
      int cv[NI];
      rst = r;
      inc = i;
      dec = d;
      // Modelled DUTs: a registered counter, or the same counter followed by two pipeline stages.
      for (int x = 0; x < NI; x++) begin
         int good;
         good = three_stage[x] ? ((k >= 2) ? hist[k-2] : 0) : hist[k];
         cv[x] = (good ^ fault[x]) & 15;
         car[x] = 4'(cv[x]);
      end
      @(posedge clk);
      if (r) begin
         clear_model();
      end else begin
         k++;
         hist.push_back(next_count(hist[k-1], i, d));
         for (int x = 0; x < NI; x++) begin
            m_val[x] = 0; m_pass[x] = 0; m_fail[x] = 0;
            if (m_halt[x] == 0) begin
               m_exp[x] = hist[k];
               if (k >= lat_of[x] + 1) begin
                  m_val[x] = 1;
                  if (m_ccnt[x] < cmax[x]) m_ccnt[x]++;
                  if (cv[x] == hist[k-lat_of[x]]) begin
                     m_pass[x] = 1;
                  end else begin
                     m_fail[x] = 1;
                     if (m_err[x] == 0) m_first[x] = k - 1;
                     m_err[x] = 1;
                     if (m_fcnt[x] < cmax[x]) m_fcnt[x]++;
                     if (stop_of[x] != 0) m_halt[x] = 1;
                  end
               end
               m_state[x] = (m_halt[x] != 0) ? 2 : ((k >= lat_of[x]) ? 1 : 0);
            end
         end
      end
      #1;
      for (int x = 0; x < NI; x++) begin
         chk($sformatf("u%0d.exp_count", x),  32'(o_exp[x]),   32'(m_exp[x]));
         chk($sformatf("u%0d.chk_valid", x),  32'(o_val[x]),   32'(m_val[x]));
         chk($sformatf("u%0d.chk_pass", x),   32'(o_pass[x]),  32'(m_pass[x]));
         chk($sformatf("u%0d.chk_fail", x),   32'(o_fail[x]),  32'(m_fail[x]));
         chk($sformatf("u%0d.err_sticky", x), 32'(o_err[x]),   32'(m_err[x]));
         chk($sformatf("u%0d.fail_cnt", x),   32'(o_fcnt[x]),  32'(m_fcnt[x]));
         chk($sformatf("u%0d.check_cnt", x),  32'(o_ccnt[x]),  32'(m_ccnt[x]));
         chk($sformatf("u%0d.first_fail", x), o_first[x],      32'(m_first[x]));
         chk($sformatf("u%0d.state", x),      32'(o_state[x]), 32'(m_state[x]));
      end
      for (int x = 0; x < NI; x++) fault[x] = 0;
   endtask

   initial begin
      rst = 1'b1;
      inc = 1'b0;
      dec = 1'b0;
      for (int x = 0; x < NI; x++) begin
         fault[x] = 0;
         car[x]   = '0;
      end
      clear_model();

      // Reset, then count up past the ceiling.
      step(1, 0, 0);
      step(1, 0, 0);
      for (int n = 0; n < 20; n++) step(0, 1, 0);
      chk("sat_at_15", 32'(o_exp[0]), 32'd15);
      chk("no_fail_after_inc", 32'(o_fcnt[0]), 32'd0);

      // Paired events hold, then drain to the floor.
      for (int n = 0; n < 3; n++) step(0, 1, 1);
      chk("paired_hold", 32'(o_exp[0]), 32'd15);
      for (int n = 0; n < 16; n++) step(0, 0, 1);
      chk("floor_at_0", 32'(o_exp[0]), 32'd0);
      chk("lat3_clean", 32'(o_err[1]), 32'd0);

      // Fault injection: two faults on the LAT=1 checker, one on the stop-on-fail checker.
      for (int n = 0; n < 5; n++) step(0, 1, 0);
      fault[0] = 12;
      step(0, 0, 0);
      for (int n = 0; n < 6; n++) step(0, 1, 0);
      fault[0] = 1;
      fault[3] = 2;
      step(0, 1, 0);
      chk("second_fault_cnt", 32'(o_fcnt[0]), 32'd2);
      for (int n = 0; n < 5; n++) step(0, 1, 0);
      chk("halt_state", 32'(o_state[3]), 32'd2);

      // Mid-run reset with the count at 7.
      step(1, 0, 0);
      for (int n = 0; n < 7; n++) step(0, 1, 0);
      chk("count_at_7", 32'(o_exp[0]), 32'd7);
      step(1, 0, 0);
      chk("reset_exp", 32'(o_exp[0]), 32'd0);
      chk("reset_state", 32'(o_state[3]), 32'd0);

      // Randomised traffic with occasional resets and faults.
      for (int n = 0; n < 200; n++) begin
         bit r, i, d;
         r = ($urandom_range(0, 49) == 0);
         i = 1'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 11) == 0) fault[0] = $urandom_range(1, 15);
         if ($urandom_range(0, 29) == 0) fault[3] = $urandom_range(1, 15);
         if ($urandom_range(0, 29) == 0) fault[1] = $urandom_range(1, 15);
         step(r, i, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
